// File: rtl/poly_tone_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poly_tone_gen_pkg
// Brief    : Shared types, note divider table and channel state for
//            poly_tone_gen. TONE_OCTAVE_EN widens the divider by one bit.
// Revision : 1.0 - initial release
// ============================================================================
package poly_tone_gen_pkg;

`ifdef TONE_OCTAVE_EN
    localparam int DIV_W = 23;
`else
    localparam int DIV_W = 22;
`endif
    localparam int CODE_W = 7;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_RELEASE = 2'd2
    } key_event_e;

    typedef struct packed {
        logic              busy;
        logic [CODE_W-1:0] code;
        logic [DIV_W-1:0]  div;
        logic [DIV_W-1:0]  cnt;
        logic              phase;
    } ch_state_t;

    localparam ch_state_t c_CH_IDLE = '0;

    // Half-period counts at 100 MHz; zero marks a code that is not a note.
    function automatic logic [DIV_W-1:0] note_div(input logic [CODE_W-1:0] code);
        logic [DIV_W-1:0] d;
        case (code)
            7'd99:   d = DIV_W'(191571);
            7'd100:  d = DIV_W'(170648);
            7'd101:  d = DIV_W'(151515);
            7'd102:  d = DIV_W'(143266);
            7'd103:  d = DIV_W'(127551);
            7'd97:   d = DIV_W'(113636);
            7'd98:   d = DIV_W'(101215);
            7'd67:   d = DIV_W'(95420);
            7'd68:   d = DIV_W'(85034);
            7'd69:   d = DIV_W'(75758);
            7'd70:   d = DIV_W'(71633);
            7'd71:   d = DIV_W'(63775);
            7'd65:   d = DIV_W'(56818);
            7'd66:   d = DIV_W'(50607);
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_tone_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_tone_gen_if
// Brief    : Key event / status / sample bundle of poly_tone_gen. The octave
//            signal exists only when TONE_OCTAVE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_tone_gen_if #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16
);
    logic                       key_valid;
    logic [6:0]                 key_code;
    logic                       key_make;
`ifdef TONE_OCTAVE_EN
    logic [1:0]                 octave;
`endif
    logic [NUM_CH-1:0]          ch_busy;
    logic                       drop;
    logic signed [SAMPLE_W-1:0] sample_out;

    modport master (
`ifdef TONE_OCTAVE_EN
        output octave,
`endif
        output key_valid, key_code, key_make,
        input  ch_busy, drop, sample_out
    );

    modport slave (
`ifdef TONE_OCTAVE_EN
        input  octave,
`endif
        input  key_valid, key_code, key_make,
        output ch_busy, drop, sample_out
    );
endinterface
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// ============================================================================
// Module   : tone_channel
// Brief    : One tone voice: latches note code and divider on allocation,
//            toggles its square phase every div cycles while busy.
// Revision : 1.0 - initial release
// ============================================================================
module tone_channel
    import poly_tone_gen_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_alloc,
    input  wire logic              i_free,
    input  wire logic [CODE_W-1:0] i_code,
    input  wire logic [DIV_W-1:0]  i_div,
    output logic                   o_busy,
    output logic [CODE_W-1:0]      o_code,
    output logic                   o_phase
);
    ch_state_t r_st;

    always_ff @(posedge clk) begin
        if (rst || i_free) begin
            r_st <= c_CH_IDLE;
        end else if (i_alloc) begin
            r_st.busy  <= 1'b1;
            r_st.code  <= i_code;
            r_st.div   <= i_div;
            r_st.cnt   <= '0;
            r_st.phase <= 1'b0;
        end else if (r_st.busy) begin
            if (r_st.cnt == r_st.div - DIV_W'(1)) begin
                r_st.cnt   <= '0;
                r_st.phase <= ~r_st.phase;
            end else begin
                r_st.cnt <= r_st.cnt + DIV_W'(1);
            end
        end
    end

    assign o_busy  = r_st.busy;
    assign o_code  = r_st.code;
    assign o_phase = r_st.phase;
endmodule
`default_nettype wire

// File: rtl/poly_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : poly_tone_gen
// Brief    : Polyphonic square-wave tone generator: allocates key presses to
//            channels and mixes them into a signed PCM sample.
//            Define TONE_OCTAVE_EN to add per-press octave selection.
// Revision : 1.0 - initial release
// ============================================================================
module poly_tone_gen
    import poly_tone_gen_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int AMPLITUDE = 4096,
    parameter int SAMPLE_W  = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    poly_tone_gen_if.slave bus
);
    localparam logic signed [SAMPLE_W-1:0] c_POS = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0] c_NEG = -c_POS;

    logic [DIV_W-1:0]           w_base;
    logic [DIV_W-1:0]           w_div;
    key_event_e                 w_event;
    logic [NUM_CH-1:0]          w_busy;
    logic [NUM_CH-1:0]          w_phase;
    logic [NUM_CH-1:0]          w_match;
    logic [NUM_CH-1:0]          w_alloc;
    logic [NUM_CH-1:0]          w_free;
    logic [CODE_W-1:0]          w_code [NUM_CH];
    logic                       w_found;
    logic                       w_drop;
    logic signed [SAMPLE_W-1:0] w_sum;
    logic                       r_drop;
    logic signed [SAMPLE_W-1:0] r_sample;

    always_comb begin
        w_base  = note_div(bus.key_code);
        w_div   = w_base;
`ifdef TONE_OCTAVE_EN
        case (bus.octave)
            2'd1:    w_div = w_base << 1;
            2'd2:    w_div = w_base >> 1;
            default: w_div = w_base;
        endcase
`endif
        w_event = EV_NONE;
        if (bus.key_valid && (w_base != '0)) begin
            w_event = bus.key_make ? EV_PRESS : EV_RELEASE;
        end
    end

    // A note is held by at most one channel, so the match vector is one-hot or zero.
    always_comb begin
        w_match = '0;
        w_alloc = '0;
        w_free  = '0;
        w_found = 1'b0;
        w_drop  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_match[i] = w_busy[i] && (w_code[i] == bus.key_code);
        end
        if (w_event == EV_PRESS && !(|w_match)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_busy[i] && !w_found) begin
                    w_alloc[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
            w_drop = !w_found;
        end
        if (w_event == EV_RELEASE) begin
            w_free = w_match;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tone_channel u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_alloc (w_alloc[gi]),
            .i_free  (w_free[gi]),
            .i_code  (bus.key_code),
            .i_div   (w_div),
            .o_busy  (w_busy[gi]),
            .o_code  (w_code[gi]),
            .o_phase (w_phase[gi])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_busy[i]) begin
                w_sum = w_sum + (w_phase[i] ? c_POS : c_NEG);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop   <= 1'b0;
            r_sample <= '0;
        end else begin
            r_drop   <= w_drop;
            r_sample <= w_sum;
        end
    end

    assign bus.ch_busy    = w_busy;
    assign bus.drop       = r_drop;
    assign bus.sample_out = r_sample;
endmodule
`default_nettype wire

// File: tb/tb_poly_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_tone_gen
// Brief    : Self-checking bench for poly_tone_gen with a cycle-level model
//            (honours TONE_OCTAVE_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_tone_gen;
    localparam int NUM_CH    = 4;
    localparam int AMPLITUDE = 4096;
    localparam int SAMPLE_W  = 16;

    typedef struct {
        bit v;
        int code;
        bit make;
        int busy;
        int drop;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     m_oct = 0;

    bit     m_busy  [NUM_CH];
    int     m_code  [NUM_CH];
    longint m_alloc [NUM_CH];
    int     m_div   [NUM_CH];

    always #5 clk = ~clk;

    poly_tone_gen_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

    poly_tone_gen #(
        .NUM_CH    (NUM_CH),
        .AMPLITUDE (AMPLITUDE),
        .SAMPLE_W  (SAMPLE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int ref_div(int code);
        int d;
        case (code)
            99:  d = 191571;  100: d = 170648;  101: d = 151515;  102: d = 143266;
            103: d = 127551;  97:  d = 113636;  98:  d = 101215;  67:  d = 95420;
            68:  d = 85034;   69:  d = 75758;   70:  d = 71633;   71:  d = 63775;
            65:  d = 56818;   66:  d = 50607;
            default: d = 0;
        endcase
`ifdef TONE_OCTAVE_EN
        if (m_oct == 1) d = d * 2;
        else if (m_oct == 2) d = d / 2;
`endif
        return d;
    endfunction

    // Output level of the mix given the note states as they stood after edge t.
    function automatic int ref_sum(longint t);
        int s = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_busy[i]) begin
                s += ((((t - m_alloc[i]) / m_div[i]) % 2) == 1) ? AMPLITUDE : -AMPLITUDE;
            end
        end
        return s;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        int exp_s, exp_d, exp_b, k, d, slot;
        bit held;
        @(posedge clk);
        cyc++;
        exp_d = 0;
        if (rst) begin
            exp_s = 0;
            for (int i = 0; i < NUM_CH; i++) m_busy[i] = 0;
        end else begin
            exp_s = ref_sum(cyc - 1);
            if (bus.key_valid) begin
                k = int'(bus.key_code);
                d = ref_div(k);
                held = 0;
                slot = -1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_busy[i] && m_code[i] == k) begin
                        held = 1;
                        slot = i;
                    end
                end
                if (d != 0) begin
                    if (bus.key_make) begin
                        if (!held) begin
                            slot = -1;
                            for (int i = NUM_CH - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
                            if (slot < 0) exp_d = 1;
                            else begin
                                m_busy[slot]  = 1;
                                m_code[slot]  = k;
                                m_alloc[slot] = cyc;
                                m_div[slot]   = d;
                            end
                        end
                    end else if (held) begin
                        m_busy[slot] = 0;
                    end
                end
            end
        end
        exp_b = 0;
        for (int i = 0; i < NUM_CH; i++) if (m_busy[i]) exp_b |= (1 << i);
        #1;
        check("ch_busy", int'(bus.ch_busy), exp_b);
        check("drop", int'(bus.drop), exp_d);
        check("sample_out", int'($signed(bus.sample_out)), exp_s);
    endtask

    task automatic ev(bit v, int code, bit make);
        bus.key_valid = v;
        bus.key_code  = 7'(code);
        bus.key_make  = make;
`ifdef TONE_OCTAVE_EN
        bus.octave    = 2'(m_oct);
`endif
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic toggle_test(int code, int div);
        ev(1, code, 1);
        tick();
        check("tone_first_sample", int'($signed(bus.sample_out)), -AMPLITUDE);
        repeat (div - 2) tick();
        tick();
        check("tone_pre_toggle", int'($signed(bus.sample_out)), -AMPLITUDE);
        tick();
        check("tone_post_toggle", int'($signed(bus.sample_out)), AMPLITUDE);
        ev(1, code, 0);
        tick();
    endtask

    vec_t vecs[$];
    int   pool[16] = '{99, 100, 101, 102, 103, 97, 98, 67, 68, 69, 70, 71, 65, 66, 120, 48};

    initial begin
        vecs.push_back('{1, 99,  1, 4'b0001, 0});
        vecs.push_back('{1, 101, 1, 4'b0011, 0});
        vecs.push_back('{1, 103, 1, 4'b0111, 0});
        vecs.push_back('{1, 67,  1, 4'b1111, 0});
        vecs.push_back('{1, 68,  1, 4'b1111, 1});
        vecs.push_back('{0, 0,   0, 4'b1111, 0});
        vecs.push_back('{1, 101, 0, 4'b1101, 0});
        vecs.push_back('{1, 65,  1, 4'b1111, 0});
        vecs.push_back('{1, 120, 1, 4'b1111, 0});
        vecs.push_back('{1, 102, 0, 4'b1111, 0});
        vecs.push_back('{1, 99,  1, 4'b1111, 0});
        vecs.push_back('{1, 99,  0, 4'b1110, 0});
        vecs.push_back('{1, 120, 0, 4'b1110, 0});
        vecs.push_back('{1, 70,  1, 4'b1111, 0});
        vecs.push_back('{1, 66,  0, 4'b1111, 0});
        vecs.push_back('{1, 66,  1, 4'b1111, 1});

        bus.key_valid = 1'b0;
        bus.key_code  = '0;
        bus.key_make  = 1'b0;
`ifdef TONE_OCTAVE_EN
        bus.octave    = 2'd0;
`endif
        rst = 1'b1;
        ev(1, 99, 1);
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            ev(vecs[i].v, vecs[i].code, vecs[i].make);
            check("vec_busy", int'(bus.ch_busy), vecs[i].busy);
            check("vec_drop", int'(bus.drop), vecs[i].drop);
        end

        // Reset with three notes held; a press in the same cycle must be lost.
        ev(1, 70, 0);
        check("three_busy", int'(bus.ch_busy), 4'b1110);
        rst = 1'b1;
        ev(1, 66, 1);
        check("rst_busy", int'(bus.ch_busy), 0);
        check("rst_sample", int'($signed(bus.sample_out)), 0);
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", int'(bus.ch_busy), 0);
        check("post_rst_sample", int'($signed(bus.sample_out)), 0);

        toggle_test(66, 50607);
`ifdef TONE_OCTAVE_EN
        m_oct = 2;
        toggle_test(66, 25303);
        m_oct = 0;
`endif

        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            m_oct = int'($urandom_range(0, 3));
            if (r < 2) begin
                rst = 1'b1;
                ev(0, 0, 0);
                rst = 1'b0;
            end else if (r < 55) begin
                ev(1, pool[$urandom_range(0, 15)], 1'($urandom_range(0, 1)));
            end else begin
                ev(0, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
